// File: rtl/pmem_arbiter_pkg.sv
// Shared definitions for the PMEM arbiter.
//   - arb_state_t : FSM encoding (IDLE / ISSUE / WAIT)
//   - owner_t     : which requester owns the in-flight transaction
//   - BYTE / HALF_WORD / WORD : byte-mask constants of the op_PMEM encoding
package pmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [7:0] BYTE      = 8'b0000_0001;
    localparam logic [7:0] HALF_WORD = 8'b0000_0011;
    localparam logic [7:0] WORD      = 8'b0000_1111;

    // Map an access size code (0 = byte, 1 = half, otherwise word) to its mask.
    function automatic logic [7:0] mask_for_size(input logic [1:0] size);
        case (size)
            2'd0:    return BYTE;
            2'd1:    return HALF_WORD;
            default: return WORD;
        endcase
    endfunction

endpackage

// File: rtl/pmem_arb_pick.sv
// Combinational grant selector for the PMEM arbiter.
// Ports:
//   ifu_valid, lsu_valid : request lines
//   last_grant           : owner of the most recently accepted request
//   grant_valid          : at least one requester is asking
//   grant                : winning requester (meaningful when grant_valid)
// On a tie the LSU wins in fixed-priority mode; in round-robin mode the
// requester that was not granted last wins.
module pmem_arb_pick
    import pmem_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant
);

    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant       = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
            if (ROUND_ROBIN != 0) begin
                grant = (last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
            end else begin
                grant = OWN_LSU;
            end
        end else if (lsu_valid) begin
            grant = OWN_LSU;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single PMEM port between the instruction fetch unit (IFU) and
// the load/store unit (LSU). One transaction at a time: accept and latch in
// IDLE, present downstream in ISSUE until mem_ready, wait for the response in
// WAIT, then route the response to the owner. A watchdog aborts transactions
// that stay in ISSUE/WAIT too long.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   ifu_req_valid/ready, ifu_addr      : IFU request handshake
//   ifu_resp_valid, ifu_rdata          : IFU response strobe and data
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask : LSU request
//   lsu_resp_valid, lsu_rdata          : LSU response strobe and data
//   resp_err                           : current response is a timeout abort
//   mem_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask : downstream request
//   mem_resp_valid, mem_rdata          : downstream response
//   err_sticky                         : a timeout has happened since reset
// Handshake: a request transfers on a cycle where valid and ready are both 1;
// the requester holds valid and its fields stable until then. req_ready is
// only raised in IDLE. Responses are single-cycle strobes with no back-pressure.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MASK_W      = 8,
    parameter int ROUND_ROBIN = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_sticky
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_t        state, state_nxt;
    owner_t            owner_q, last_grant_q, grant;
    logic              grant_valid;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [WD_W-1:0]   wdog_q;
    logic              err_sticky_q;
    logic              accept, timeout, resp_fire;

    pmem_arb_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_nxt = state;
        // rst_n gates ready so that a requester holding valid through reset
        // never sees a handshake while the arbiter is held in reset.
        accept    = rst_n && (state == IDLE) && grant_valid;
        // The watchdog wins over a response arriving in the abort cycle.
        timeout   = (state != IDLE) && (wdog_q == WD_W'(TIMEOUT));
        resp_fire = timeout
                 || ((state == ISSUE) && mem_ready && mem_resp_valid)
                 || ((state == WAIT) && mem_resp_valid);

        case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE: begin
                if (timeout)        state_nxt = IDLE;
                else if (mem_ready) state_nxt = mem_resp_valid ? IDLE : WAIT;
            end
            WAIT:    if (timeout || mem_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        ifu_req_ready  = accept && (grant == OWN_IFU);
        lsu_req_ready  = accept && (grant == OWN_LSU);
        mem_valid      = (state == ISSUE) && !timeout;
        ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
        lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
        resp_err       = timeout;
        ifu_rdata      = (ifu_resp_valid && !timeout) ? mem_rdata : '0;
        lsu_rdata      = (lsu_resp_valid && !timeout) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            wdog_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                wdog_q       <= '0;
                if (grant == OWN_LSU) begin
                    addr_q  <= lsu_addr;
                    wen_q   <= lsu_wen;
                    wdata_q <= lsu_wdata;
                    wmask_q <= lsu_wmask;
                end else begin
                    // Fetches are always full-width reads.
                    addr_q  <= ifu_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '1;
                end
            end else if (state != IDLE) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (timeout) err_sticky_q <= 1'b1;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wen    = wen_q;
    assign mem_wdata  = wdata_q;
    assign mem_wmask  = wmask_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          resp_err, mem_valid, mem_ready, mem_wen, mem_resp_valid, err_sticky;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    pmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .ROUND_ROBIN(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .err_sticky(err_sticky)
    );

    // Fixed-priority selector checked on its own.
    logic   p_ifu = 1'b0, p_lsu = 1'b0, p_gv;
    owner_t p_last = OWN_IFU, p_grant;
    pmem_arb_pick #(.ROUND_ROBIN(0)) u_pick_fp (
        .ifu_valid(p_ifu), .lsu_valid(p_lsu), .last_grant(p_last),
        .grant_valid(p_gv), .grant(p_grant)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } req_t;
    typedef struct packed {
        logic          is_lsu;
        logic          err;
        logic          chk_data;
        logic [DW-1:0] rdata;
    } resp_t;

    req_t  exp_req_q[$];
    resp_t exp_resp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    ifu_rdy_cnt = 0, lsu_rdy_cnt = 0;
    int    ifu_resp_cyc = -1, lsu_resp_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5a5a_5a5a);
    endfunction

    // Downstream request monitor: fields checked every presented cycle, popped on accept.
    always @(negedge clk) begin
        if (rst_n && mem_valid) begin
            if (exp_req_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mem_req: unexpected request addr 0x%0h", mem_addr);
            end else begin
                check("mem_addr",  mem_addr,  exp_req_q[0].addr);
                check("mem_wen",   mem_wen,   exp_req_q[0].wen);
                check("mem_wdata", mem_wdata, exp_req_q[0].wdata);
                check("mem_wmask", mem_wmask, exp_req_q[0].wmask);
                if (mem_ready) void'(exp_req_q.pop_front());
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        resp_t e;
        if (rst_n) begin
            if (ifu_req_ready) ifu_rdy_cnt++;
            if (lsu_req_ready) lsu_rdy_cnt++;
            if (ifu_resp_valid) ifu_resp_cyc = cyc;
            if (lsu_resp_valid) lsu_resp_cyc = cyc;
            if (ifu_resp_valid || lsu_resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL resp: unexpected response ifu=%0b lsu=%0b", ifu_resp_valid, lsu_resp_valid);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("resp_owner", {ifu_resp_valid, lsu_resp_valid}, e.is_lsu ? 2'b01 : 2'b10);
                    check("resp_err", resp_err, e.err);
                    if (e.chk_data) check("resp_rdata", e.is_lsu ? lsu_rdata : ifu_rdata, e.rdata);
                    check("nonowner_rdata", e.is_lsu ? ifu_rdata : lsu_rdata, 0);
                    if (e.err) check("abort_mem_valid", mem_valid, 1'b0);
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    // mode 0: normal, 1: never respond, 2: accept then never respond
    int mem_mode = 0, ready_dly = 0, resp_dly = 0;
    bit same_cycle = 0;
    int stale_req_cnt = 0, stale_done_cnt = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        forever begin
            tick();
            if (stale_req_cnt != stale_done_cnt) begin
                mem_resp_valid = 1'b1; mem_rdata = 32'hdead_beef; stale_done_cnt++;
                tick();
                mem_resp_valid = 1'b0; mem_rdata = '0;
            end else if (mem_valid && mem_mode == 0) begin
                repeat (ready_dly) tick();
                mem_ready = 1'b1;
                if (same_cycle) begin mem_resp_valid = 1'b1; mem_rdata = mem_data(mem_addr); end
                tick();
                mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
                if (!same_cycle) begin
                    repeat (resp_dly) tick();
                    mem_resp_valid = 1'b1; mem_rdata = mem_data(mem_addr);
                    tick();
                    mem_resp_valid = 1'b0; mem_rdata = '0;
                end
            end else if (mem_valid && mem_mode == 2) begin
                mem_ready = 1'b1;
                tick();
                mem_ready = 1'b0;
            end
        end
    end

    // ---------------- requester drivers ----------------
    task automatic ifu_req(input logic [AW-1:0] a, output int acc);
        ifu_req_valid = 1'b1; ifu_addr = a; acc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ifu_req_ready) begin acc = cyc; break; end
        end
        tick();
        ifu_req_valid = 1'b0;
        if (acc < 0) begin n_checks++; n_fail++; $display("FAIL ifu_accept: no ready within 64 cycles"); end
    endtask

    task automatic lsu_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           input logic [MW-1:0] m, output int acc);
        lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wmask = m; acc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (lsu_req_ready) begin acc = cyc; break; end
        end
        tick();
        lsu_req_valid = 1'b0;
        if (acc < 0) begin n_checks++; n_fail++; $display("FAIL lsu_accept: no ready within 64 cycles"); end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_resp_q.size() == 0) break;
            tick();
        end
        check("drain_resp_q", exp_resp_q.size(), 0);
    endtask

    task automatic push_ifu(input logic [AW-1:0] a);
        exp_req_q.push_back('{addr: a, wen: 1'b0, wdata: '0, wmask: '1});
        exp_resp_q.push_back('{is_lsu: 1'b0, err: 1'b0, chk_data: 1'b1, rdata: mem_data(a)});
    endtask

    task automatic push_lsu(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                            input logic [MW-1:0] m);
        exp_req_q.push_back('{addr: a, wen: w, wdata: d, wmask: m});
        exp_resp_q.push_back('{is_lsu: 1'b1, err: 1'b0, chk_data: !w, rdata: mem_data(a)});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int a0, a1, rel, r0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;

        // Reset values
        repeat (2) tick();
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_ifu_ready", ifu_req_ready, 1'b0);
        check("rst_lsu_ready", lsu_req_ready, 1'b0);
        check("rst_ifu_resp", ifu_resp_valid, 1'b0);
        check("rst_lsu_resp", lsu_resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_err_sticky", err_sticky, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_ifu_rdata", ifu_rdata, 0);
        rst_n = 1'b1;
        rel = cyc;

        // 1: single IFU fetch, ready after 2 cycles, response 1 cycle later
        mem_mode = 0; ready_dly = 2; resp_dly = 0; same_cycle = 0;
        r0 = ifu_rdy_cnt;
        push_ifu(32'h8000_0000);
        ifu_req(32'h8000_0000, a0);
        wait_drain();
        check("t1_accept_cycle", a0, rel);
        check("t1_ready_pulses", ifu_rdy_cnt - r0, 1);
        check("t1_resp_cycle", ifu_resp_cyc, a0 + 4);

        // 2: tie, LSU store first, IFU taken in the first IDLE after
        ready_dly = 0; resp_dly = 0;
        push_lsu(32'h8000_1000, 1'b1, 32'h1234_5678, WORD);
        push_ifu(32'h8000_0100);
        fork
            lsu_req(32'h8000_1000, 1'b1, 32'h1234_5678, WORD, a0);
            ifu_req(32'h8000_0100, a1);
        join
        wait_drain();
        check("t2_ifu_after_lsu", a1 - a0, 3);

        // 3: round robin, both held valid for 4 transactions
        ready_dly = 1; resp_dly = 1;
        push_lsu(32'h8000_2000, 1'b0, '0, BYTE);
        push_ifu(32'h8000_0200);
        push_lsu(32'h8000_2004, 1'b0, '0, HALF_WORD);
        push_ifu(32'h8000_0204);
        fork
            begin
                lsu_req(32'h8000_2000, 1'b0, '0, BYTE, a0);
                lsu_req(32'h8000_2004, 1'b0, '0, HALF_WORD, a0);
            end
            begin
                ifu_req(32'h8000_0200, a1);
                ifu_req(32'h8000_0204, a1);
            end
        join
        wait_drain();

        // 4: ready and response in the same ISSUE cycle
        ready_dly = 0; same_cycle = 1;
        push_lsu(32'h8000_3000, 1'b0, '0, WORD);
        push_ifu(32'h8000_0300);
        fork
            lsu_req(32'h8000_3000, 1'b0, '0, WORD, a0);
            begin tick(); ifu_req(32'h8000_0300, a1); end
        join
        wait_drain();
        check("t4_resp_cycle", lsu_resp_cyc, a0 + 1);
        check("t4_next_accept", a1 - a0, 2);
        same_cycle = 0;

        // 5: watchdog abort, then a stale response in IDLE
        mem_mode = 1;
        exp_req_q.push_back('{addr: 32'h8000_0400, wen: 1'b0, wdata: '0, wmask: '1});
        exp_resp_q.push_back('{is_lsu: 1'b0, err: 1'b1, chk_data: 1'b1, rdata: '0});
        ifu_req(32'h8000_0400, a0);
        wait_drain();
        check("t5_abort_cycle", ifu_resp_cyc, a0 + TO + 1);
        check("t5_err_sticky", err_sticky, 1'b1);
        exp_req_q.delete();
        @(negedge clk);
        stale_req_cnt++;
        tick();
        @(negedge clk);
        check("t5_stale_ifu_resp", ifu_resp_valid, 1'b0);
        check("t5_stale_lsu_resp", lsu_resp_valid, 1'b0);
        check("t5_stale_ifu_rdata", ifu_rdata, 0);
        tick();

        // 6: reset while in WAIT
        mem_mode = 2;
        exp_req_q.push_back('{addr: 32'h8000_0500, wen: 1'b0, wdata: '0, wmask: '1});
        ifu_req(32'h8000_0500, a0);
        tick();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_mem_valid", mem_valid, 1'b0);
        check("t6_ifu_ready", ifu_req_ready, 1'b0);
        check("t6_lsu_ready", lsu_req_ready, 1'b0);
        check("t6_ifu_resp", ifu_resp_valid, 1'b0);
        check("t6_err_sticky", err_sticky, 1'b0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t6_state_idle", dut.state, IDLE);
        mem_mode = 0; ready_dly = 0; resp_dly = 1;
        push_ifu(32'h8000_0600);
        ifu_req(32'h8000_0600, a0);
        wait_drain();
        check("t6_req_q_empty", exp_req_q.size(), 0);

        // Fixed-priority selector table
        p_ifu = 1; p_lsu = 1; p_last = OWN_LSU; #1;
        check("fp_tie_lastlsu", p_grant, OWN_LSU);
        p_last = OWN_IFU; #1;
        check("fp_tie_lastifu", p_grant, OWN_LSU);
        p_lsu = 0; p_last = OWN_LSU; #1;
        check("fp_ifu_only", p_grant, OWN_IFU);
        check("fp_ifu_only_gv", p_gv, 1'b1);
        p_ifu = 0; #1;
        check("fp_none_gv", p_gv, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
